exc_check_scheduler: RTL and testbench
======================================

# exc_check_scheduler

Shares one `exceptionChecker` instance among `NREQ` requesters, such as operand A, operand B and the result stage of the FPU.
- Arbitrates round-robin between requesters.
- Drives the checker's `Data`/`Data_valid` and waits for its `ACK` pulse.
- Captures `Exc` and returns it to the granted requester with a one-cycle `Done` pulse.
- Guards against a checker that never acknowledges with a timeout.

## Interface
Parameters:
- `NREQ`, 3, number of requesters (2..8).
- `TIMEOUT`, 15, cycles in Issue without `ChkAck` before the scheduler aborts.

Ports:
- `CLK`  in  1  clock. One clock domain.
- `RST`  in  1  reset. Synchronous, active-high.
- `Req`  in  NREQ  per-requester request level. Held by the requester until its `Done` bit pulses.
- `ReqData`  in  NREQ*32  packed IEEE-754 singles. Slice i is `[32*i+31:32*i]`.
- `Done`  out  NREQ  one-hot, one-cycle completion pulse.
- `ExcOut`  out  3  exception code. Valid in the `Done` cycle and held until the next `Done`.
- `Busy`  out  1  high in every state other than Idle.
- `ChkData`  out  32  to checker `Data`.
- `ChkValid`  out  1  to checker `Data_valid`.
- `ChkExc`  in  3  from checker `Exc`.
- `ChkAck`  in  1  from checker `ACK`.

## Operation
- Three states: Idle, Issue and Cooldown.
- **Idle:**
  - If `Req` is nonzero, pick grant index g by round-robin, starting the search at `ptr`.
  - Register `ChkData` ← slice g, `ChkValid` ← 1 and timeout counter ← 0, then go to Issue.
  - If `Req` is zero, stay in Idle.
- **Issue:** hold `ChkData` and `ChkValid` stable. Each edge:
  - If `ChkAck`=1:
    - `ExcOut` ← `ChkExc`, `Done[g]` ← 1.
    - `ChkValid` ← 0, `ptr` ← (g+1) mod NREQ.
    - Go to Cooldown.
  - Else if counter = `TIMEOUT`:
    - `ExcOut` ← `EXC_TIMEOUT` (3'b111), `Done[g]` ← 1.
    - `ChkValid` ← 0, `ptr` ← (g+1) mod NREQ.
    - Go to Cooldown.
  - Otherwise, counter ← counter + 1. Counter width is `$clog2(TIMEOUT+1)` and it never wraps.
- **Cooldown:** `ChkValid` stays 0, which lets the checker pass through its reset-output phase.
  - Go to Idle on the first edge where `ChkAck`=0.
  - Stay in Cooldown while `ChkAck`=1.
- `ExcOut` passes the checker code through unchanged: 3'b011 = infinity, 3'b100 = NaN. The 3'b111 timeout code is generated only by the scheduler.
- The grant is fixed for the whole transaction. If `Req[g]` drops mid-transaction, the transaction still completes and `Done[g]` still pulses.
- A requester that re-asserts `Req` in the cycle after its `Done` is eligible at the next Idle. It ranks lowest, because `ptr` has moved past it.
- Multiple simultaneous `Req` bits: the lowest index at or above `ptr` (cyclic) wins. The others wait; there is no starvation.

## Timing
- All outputs are registered. Reset values:
  - `Done`=0, `ExcOut`=0, `ChkData`=0, `ChkValid`=0, `Busy`=0.
  - State=Idle, `ptr`=0, counter=0.
- `RST` in any state returns all of the above on the next edge.
  - An in-flight transaction is dropped; no `Done` is issued for it.
  - `ChkValid` is low the cycle after `RST`.
- Minimum latency:
  - `Req` sampled at edge n → `ChkValid` high after n.
  - `ChkAck` sampled at n+1 → `Done` high after n+1, i.e. 2 cycles.
- Throughput: at most one transaction per 3 cycles (Idle → Issue → Cooldown).
- Timeout: `Done` with 3'b111 arrives exactly `TIMEOUT`+2 cycles after `Req` is sampled.
- `ChkAck` already high when Issue is entered is taken as the acknowledge on the first Issue edge.

## Structure
- Shared package `fpu_pkg` holds:
  - Constants `EXC_NONE`=3'b000, `EXC_INF`=3'b011, `EXC_NAN`=3'b100, `EXC_TIMEOUT`=3'b111.
  - The `SchedState` enum {Idle, Issue, Cooldown}.
- Sub-module `rr_arbiter`: combinational round-robin pick, taking `Req` and `ptr` and returning one-hot and binary grant, parameterised by `NREQ`.
- The state machine, timeout counter and output registers live in `exc_check_scheduler`.

## Test plan
- Single request: `Req`=3'b001, `ReqData[31:0]`=32'h7F800000, checker acks 1 cycle after `ChkValid` rises → `Done`=3'b001 two cycles after `Req`, `ExcOut`=3'b011.
- Contention: `Req`=3'b111 held, data slices 32'h7FC00000, 32'h7F800000, 32'h3F800000 → `Done` order 001, 010, 100, with 3-cycle spacing and `ExcOut` 100 then 011.
- Fairness: after servicing index 0, `Req`=3'b011 → index 1 is granted first, then index 0.
- Timeout: `Req`=3'b010, `ChkAck` tied 0 → `Done`=3'b010 with `ExcOut`=3'b111 exactly 17 cycles after `Req` sampled, then `ChkValid`=0.
- Reset mid-Issue: assert `RST` while `ChkValid`=1 → next cycle `ChkValid`=0, `Busy`=0, no `Done`, `ptr`=0.
- Stuck ack: `ChkAck` held 1 for 4 cycles after the acknowledge → scheduler stays in Cooldown, `ChkValid`=0, and the next Issue starts only after `ChkAck` falls.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exception codes and the exception-check scheduler state type.
package fpu_pkg;

  localparam logic [2:0] EXC_NONE    = 3'b000;
  localparam logic [2:0] EXC_INF     = 3'b011;
  localparam logic [2:0] EXC_NAN     = 3'b100;
  localparam logic [2:0] EXC_TIMEOUT = 3'b111;

  typedef enum logic [1:0] {
    Idle,
    Issue,
    Cooldown
  } SchedState;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr_i, searched cyclically.
module rr_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] gnt_idx_o,
  output logic                    valid_o
);

  localparam int unsigned IdxW = $clog2(NREQ);

  logic [IdxW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IdxW'((32'(ptr_i) + k) % NREQ);
      if (!valid_o && req_i[idx]) begin
        valid_o    = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/exc_check_scheduler.sv
// Time-shares one exception checker among NREQ requesters with round-robin grant and an
// acknowledge timeout; all outputs are registered.
module exc_check_scheduler
  import fpu_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   Req,
  input  logic [NREQ*32-1:0] ReqData,
  output logic [NREQ-1:0]   Done,
  output logic [2:0]        ExcOut,
  output logic              Busy,
  output logic [31:0]       ChkData,
  output logic              ChkValid,
  input  logic [2:0]        ChkExc,
  input  logic              ChkAck
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  SchedState       state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [2:0]      exc_q, exc_d;
  logic [31:0]     chk_data_q, chk_data_d;
  logic            chk_valid_q, chk_valid_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IdxW-1:0] arb_idx;
  logic            arb_valid;
  logic [31:0]     slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = ReqData[32*i +: 32];
  end

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req_i    (Req),
    .ptr_i    (ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_idx_o(arb_idx),
    .valid_o  (arb_valid)
  );

  logic finish;
  logic [2:0] finish_exc;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    done_d      = '0;
    exc_d       = exc_q;
    chk_data_d  = chk_data_q;
    chk_valid_d = chk_valid_q;
    finish      = 1'b0;
    finish_exc  = EXC_NONE;

    unique case (state_q)
      Idle: begin
        if (arb_valid) begin
          gnt_d       = arb_gnt;
          gidx_d      = arb_idx;
          chk_data_d  = slice[arb_idx];
          chk_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = Issue;
        end
      end
      Issue: begin
        // Acknowledge wins over timeout when both land on the same edge.
        if (ChkAck) begin
          finish     = 1'b1;
          finish_exc = ChkExc;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          finish     = 1'b1;
          finish_exc = EXC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      Cooldown: begin
        if (!ChkAck) state_d = Idle;
      end
      default: state_d = Idle;
    endcase

    if (finish) begin
      exc_d       = finish_exc;
      done_d      = gnt_q;
      chk_valid_d = 1'b0;
      ptr_d       = (gidx_q == IdxW'(NREQ - 1)) ? '0 : gidx_q + IdxW'(1);
      state_d     = Cooldown;
    end

    busy_d = (state_d != Idle);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= Idle;
      ptr_q       <= '0;
      gidx_q      <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      done_q      <= '0;
      exc_q       <= EXC_NONE;
      chk_data_q  <= '0;
      chk_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      exc_q       <= exc_d;
      chk_data_q  <= chk_data_d;
      chk_valid_q <= chk_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign Done     = done_q;
  assign ExcOut   = exc_q;
  assign Busy     = busy_q;
  assign ChkData  = chk_data_q;
  assign ChkValid = chk_valid_q;

endmodule

// File: tb/tb_exc_check_scheduler.sv
// Transaction-level bench for exc_check_scheduler: the bench plays requesters and checker and
// predicts grant order, latency and exception codes from the round-robin and timeout rules.
module tb_exc_check_scheduler;
  import fpu_pkg::*;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned TIMEOUT = 15;

  logic               CLK = 1'b0;
  logic               RST;
  logic [NREQ-1:0]    Req;
  logic [NREQ*32-1:0] ReqData;
  logic [NREQ-1:0]    Done;
  logic [2:0]         ExcOut;
  logic               Busy;
  logic [31:0]        ChkData;
  logic               ChkValid;
  logic [2:0]         ChkExc;
  logic               ChkAck;

  exc_check_scheduler #(
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Req     (Req),
    .ReqData (ReqData),
    .Done    (Done),
    .ExcOut  (ExcOut),
    .Busy    (Busy),
    .ChkData (ChkData),
    .ChkValid(ChkValid),
    .ChkExc  (ChkExc),
    .ChkAck  (ChkAck)
  );

  always #5 CLK = ~CLK;

  int         checks   = 0;
  int         failures = 0;
  int         m_ptr    = 0;
  logic [2:0] m_exc    = EXC_NONE;
  logic [2:0] codes [3] = '{EXC_NONE, EXC_INF, EXC_NAN};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Round-robin rule: first requesting index at or after p, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (p + k) % NREQ;
      if (((r >> idx) & NREQ'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic sample(input string tag, input bit v, input logic [31:0] d,
                        input logic [NREQ-1:0] dn, input bit b);
    check_eq({tag, ".valid"}, 32'(ChkValid), 32'(v));
    if (v) check_eq({tag, ".data"}, ChkData, d);
    check_eq({tag, ".done"}, 32'(Done), 32'(dn));
    check_eq({tag, ".busy"}, 32'(Busy), 32'(b));
    check_eq({tag, ".exc"}, 32'(ExcOut), 32'(m_exc));
  endtask

  // One full transaction from Idle back to Idle. dly<0 means the checker never acknowledges.
  task automatic run_txn(input logic [NREQ-1:0] req, input int dly, input logic [2:0] code,
                         input int stuck, input bit drop_mid, input bit pre_ack);
    int              g;
    logic [31:0]     d;
    logic [NREQ-1:0] oh;
    g  = pick(req, m_ptr);
    if (g < 0) return;
    d  = 32'(ReqData >> (32 * g));
    oh = NREQ'(1) << g;
    Req    = req;
    ChkAck = pre_ack && (dly >= 0);
    ChkExc = code;
    @(negedge CLK);
    sample("issue", 1'b1, d, '0, 1'b1);
    if (drop_mid) Req = Req & ~oh;
    if (dly < 0) begin
      ChkAck = 1'b0;
      repeat (TIMEOUT) begin
        @(negedge CLK);
        sample("wait_to", 1'b1, d, '0, 1'b1);
      end
      m_exc = EXC_TIMEOUT;
    end else begin
      if (!pre_ack) begin
        ChkAck = 1'b0;
        repeat (dly) begin
          @(negedge CLK);
          sample("wait_ack", 1'b1, d, '0, 1'b1);
        end
        ChkAck = 1'b1;
      end
      m_exc = code;
    end
    @(negedge CLK);
    m_ptr = (g + 1) % NREQ;
    sample("done", 1'b0, 32'h0, oh, 1'b1);
    Req = Req & ~oh;
    repeat (stuck) begin
      ChkAck = 1'b1;
      @(negedge CLK);
      sample("cool", 1'b0, 32'h0, '0, 1'b1);
    end
    ChkAck = 1'b0;
    @(negedge CLK);
    sample("idle", 1'b0, 32'h0, '0, 1'b0);
  endtask

  task automatic reset_mid_issue(input logic [NREQ-1:0] req);
    Req    = req;
    ChkAck = 1'b0;
    @(negedge CLK);
    check_eq("rst.pre_valid", 32'(ChkValid), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    m_exc = EXC_NONE;
    m_ptr = 0;
    sample("rst", 1'b0, 32'h0, '0, 1'b0);
    RST = 1'b0;
    Req = '0;
    @(negedge CLK);
    sample("rst_idle", 1'b0, 32'h0, '0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] r;
    int              dly;
    RST = 1'b1; Req = '0; ReqData = '0; ChkExc = '0; ChkAck = 1'b0;
    repeat (2) @(negedge CLK);
    sample("reset", 1'b0, 32'h0, '0, 1'b0);
    check_eq("reset.data", ChkData, 32'h0);
    RST = 1'b0;
    @(negedge CLK);
    sample("idle0", 1'b0, 32'h0, '0, 1'b0);

    // Single request, infinity
    ReqData = {32'h3F800000, 32'h7F800000, 32'h7F800000};
    run_txn(3'b001, 0, EXC_INF, 0, 1'b0, 1'b0);
    // Reset mid-Issue returns ptr to 0
    reset_mid_issue(3'b010);
    // Contention with Req held at 111
    ReqData = {32'h3F800000, 32'h7F800000, 32'h7FC00000};
    run_txn(3'b111, 0, EXC_NAN, 0, 1'b0, 1'b0);
    run_txn(3'b111, 0, EXC_INF, 0, 1'b0, 1'b0);
    run_txn(3'b111, 0, EXC_NONE, 0, 1'b0, 1'b0);
    // Fairness
    run_txn(3'b001, 1, EXC_NONE, 0, 1'b0, 1'b0);
    run_txn(3'b011, 2, EXC_INF, 0, 1'b0, 1'b0);
    run_txn(3'b001, 0, EXC_NAN, 0, 1'b0, 1'b0);
    // Timeout, ack at the last legal cycle, stuck ack, early ack, drop mid-transaction
    run_txn(3'b010, -1, EXC_NONE, 0, 1'b0, 1'b0);
    run_txn(3'b100, TIMEOUT, EXC_NAN, 0, 1'b0, 1'b0);
    run_txn(3'b100, 1, EXC_INF, 4, 1'b0, 1'b0);
    run_txn(3'b110, 0, EXC_NAN, 0, 1'b0, 1'b1);
    run_txn(3'b011, 3, EXC_INF, 1, 1'b1, 1'b0);

    r = '0;
    for (int n = 0; n < 40; n++) begin
      ReqData = {$urandom(), $urandom(), $urandom()};
      r = r | NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if (r == '0) r = NREQ'(1) << $urandom_range(0, NREQ - 1);
      case ($urandom_range(0, 7))
        0:       dly = -1;
        1:       dly = TIMEOUT;
        default: dly = $urandom_range(0, 5);
      endcase
      run_txn(r, dly, codes[$urandom_range(0, 2)], $urandom_range(0, 3),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      r = Req;
      if ($urandom_range(0, 3) == 0) begin
        Req = '0;
        r   = '0;
        @(negedge CLK);
        sample("gap", 1'b0, 32'h0, '0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
